// File: rtl/riscv_axi_mem_arbiter_if.sv
// AXI4 channel bundle (AR/R/AW/W/B) shared by the arbiter ports.
// master drives requests and consumes responses; slave is the reverse.
interface riscv_axi_mem_arbiter_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, arlen, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/riscv_axi_mem_arbiter.sv
// Two-master to one-slave AXI4 arbiter: icache (inport0) and dcache
// (inport1) share one memory port; read and write paths arbitrate apart.
// Ports: clk_i, rst_ni (async active-low), inport0/inport1 (slave side),
// outport (master side towards memory).
module riscv_axi_mem_arbiter #(
  parameter bit ROUND_ROBIN     = 1'b1,
  parameter bit FIXED_PRIO_PORT = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  riscv_axi_mem_arbiter_if.slave  inport0,
  riscv_axi_mem_arbiter_if.slave  inport1,
  riscv_axi_mem_arbiter_if.master outport
);

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_t;

  rd_state_t rd_state;
  wr_state_t wr_state;

  logic rd_gnt;
  logic rd_ptr;
  logic rd_win;
  logic wr_gnt;
  logic wr_ptr;
  logic wr_win;

  logic rd_a;
  logic rd_d;
  logic wr_a;
  logic wr_d;
  logic wr_b;

  logic ar_v;
  logic r_rdy;
  logic aw_v;
  logic w_v;
  logic w_last;
  logic b_rdy;

  logic ar_hs;
  logic r_done;
  logic aw_hs;
  logic w_done;
  logic b_hs;

  // Lone requester wins; on a tie the port that was not granted last
  // wins (round-robin) or the fixed port wins.
  function automatic logic arb(
    input logic req0,
    input logic req1,
    input logic ptr
  );
    logic win;
    win = req1;
    if (req0 && req1) begin
      win = ROUND_ROBIN ? ~ptr : FIXED_PRIO_PORT;
    end
    return win;
  endfunction

  assign rd_win = arb(inport0.arvalid, inport1.arvalid, rd_ptr);
  assign wr_win = arb(inport0.awvalid, inport1.awvalid, wr_ptr);

  assign rd_a = (rd_state == R_ADDR);
  assign rd_d = (rd_state == R_DATA);
  assign wr_a = (wr_state == W_ADDR);
  assign wr_d = (wr_state == W_DATA);
  assign wr_b = (wr_state == W_RESP);

  // Read path

  assign ar_v  = rd_gnt ? inport1.arvalid : inport0.arvalid;
  assign r_rdy = rd_gnt ? inport1.rready  : inport0.rready;

  assign ar_hs  = rd_a & ar_v & outport.arready;
  assign r_done = rd_d & outport.rvalid & r_rdy & outport.rlast;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_state <= R_IDLE;
      rd_gnt   <= 1'b0;
      rd_ptr   <= 1'b1;
    end else begin
      unique case (rd_state)
        R_IDLE: begin
          if (inport0.arvalid || inport1.arvalid) begin
            rd_gnt   <= rd_win;
            rd_ptr   <= rd_win;
            rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (ar_hs) rd_state <= R_DATA;
        end
        R_DATA: begin
          if (r_done) rd_state <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign outport.arvalid = rd_a & ar_v;
  assign outport.araddr  = rd_gnt ? inport1.araddr  : inport0.araddr;
  assign outport.arid    = rd_gnt ? inport1.arid    : inport0.arid;
  assign outport.arlen   = rd_gnt ? inport1.arlen   : inport0.arlen;
  assign outport.arburst = rd_gnt ? inport1.arburst : inport0.arburst;
  assign outport.rready  = rd_d & r_rdy;

  assign inport0.arready = rd_a & ~rd_gnt & outport.arready;
  assign inport1.arready = rd_a &  rd_gnt & outport.arready;

  assign inport0.rvalid = rd_d & ~rd_gnt & outport.rvalid;
  assign inport1.rvalid = rd_d &  rd_gnt & outport.rvalid;

  // R payload is broadcast; only rvalid qualifies it per master.
  assign inport0.rdata = outport.rdata;
  assign inport0.rresp = outport.rresp;
  assign inport0.rid   = outport.rid;
  assign inport0.rlast = outport.rlast;
  assign inport1.rdata = outport.rdata;
  assign inport1.rresp = outport.rresp;
  assign inport1.rid   = outport.rid;
  assign inport1.rlast = outport.rlast;

  // Write path

  assign aw_v   = wr_gnt ? inport1.awvalid : inport0.awvalid;
  assign w_v    = wr_gnt ? inport1.wvalid  : inport0.wvalid;
  assign w_last = wr_gnt ? inport1.wlast   : inport0.wlast;
  assign b_rdy  = wr_gnt ? inport1.bready  : inport0.bready;

  assign aw_hs  = wr_a & aw_v & outport.awready;
  assign w_done = wr_d & w_v & outport.wready & w_last;
  assign b_hs   = wr_b & outport.bvalid & b_rdy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_state <= W_IDLE;
      wr_gnt   <= 1'b0;
      wr_ptr   <= 1'b1;
    end else begin
      unique case (wr_state)
        W_IDLE: begin
          if (inport0.awvalid || inport1.awvalid) begin
            wr_gnt   <= wr_win;
            wr_ptr   <= wr_win;
            wr_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (aw_hs) wr_state <= W_DATA;
        end
        W_DATA: begin
          if (w_done) wr_state <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) wr_state <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign outport.awvalid = wr_a & aw_v;
  assign outport.awaddr  = wr_gnt ? inport1.awaddr  : inport0.awaddr;
  assign outport.awid    = wr_gnt ? inport1.awid    : inport0.awid;
  assign outport.awlen   = wr_gnt ? inport1.awlen   : inport0.awlen;
  assign outport.awburst = wr_gnt ? inport1.awburst : inport0.awburst;

  // W beats ahead of the AW handshake stall here (wready low).
  assign outport.wvalid = wr_d & w_v;
  assign outport.wdata  = wr_gnt ? inport1.wdata : inport0.wdata;
  assign outport.wstrb  = wr_gnt ? inport1.wstrb : inport0.wstrb;
  assign outport.wlast  = w_last;
  assign outport.bready = wr_b & b_rdy;

  assign inport0.awready = wr_a & ~wr_gnt & outport.awready;
  assign inport1.awready = wr_a &  wr_gnt & outport.awready;
  assign inport0.wready  = wr_d & ~wr_gnt & outport.wready;
  assign inport1.wready  = wr_d &  wr_gnt & outport.wready;

  assign inport0.bvalid = wr_b & ~wr_gnt & outport.bvalid;
  assign inport1.bvalid = wr_b &  wr_gnt & outport.bvalid;

  assign inport0.bresp = outport.bresp;
  assign inport0.bid   = outport.bid;
  assign inport1.bresp = outport.bresp;
  assign inport1.bid   = outport.bid;

endmodule
